// File: rtl/saida_de_dados_7seg.sv
// OUT-instruction display peripheral: converts a signed 32-bit word to four BCD digits
// with a sequential double-dabble engine and drives four digit displays plus a sign display.
module saida_de_dados_7seg #(
    parameter bit ATIVO_BAIXO = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        escrita,
    input  logic [31:0] dado,
    output logic        ocupado,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  sinal
);

    typedef enum logic [1:0] {
        StOcioso,
        StConverte,
        StAtualiza
    } estado_e;

    localparam logic [6:0] SegBlank = 7'b1111111;
    localparam logic [6:0] SegMenos = 7'b0111111;
    localparam logic [6:0] SegE     = 7'b0000110;
    localparam logic [6:0] SegR     = 7'b0101111;

    function automatic logic [6:0] seg_digito(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SegBlank;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] ajusta(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    estado_e     state_q, state_d;
    logic        neg_q, neg_d;
    logic        erro_q, erro_d;
    logic [13:0] bin_q, bin_d;
    logic [15:0] bcd_q, bcd_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [6:0]  hex0_q, hex0_d;
    logic [6:0]  hex1_q, hex1_d;
    logic [6:0]  hex2_q, hex2_d;
    logic [6:0]  hex3_q, hex3_d;
    logic [6:0]  sinal_q, sinal_d;

    logic [31:0] mag;
    logic [15:0] bcd_adj;
    logic [3:0]  d0, d1, d2, d3;

    // 0x80000000 negates to itself and lands above 9999, so it takes the error path.
    assign mag     = dado[31] ? (~dado + 32'd1) : dado;
    assign bcd_adj = {ajusta(bcd_q[15:12]), ajusta(bcd_q[11:8]),
                      ajusta(bcd_q[7:4]), ajusta(bcd_q[3:0])};
    assign d3      = bcd_q[15:12];
    assign d2      = bcd_q[11:8];
    assign d1      = bcd_q[7:4];
    assign d0      = bcd_q[3:0];

    always_comb begin
        state_d = state_q;
        neg_d   = neg_q;
        erro_d  = erro_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        hex0_d  = hex0_q;
        hex1_d  = hex1_q;
        hex2_d  = hex2_q;
        hex3_d  = hex3_q;
        sinal_d = sinal_q;
        case (state_q)
            StOcioso: begin
                if (escrita) begin
                    neg_d = dado[31];
                    if (mag > 32'd9999) begin
                        erro_d  = 1'b1;
                        state_d = StAtualiza;
                    end else begin
                        erro_d  = 1'b0;
                        bin_d   = mag[13:0];
                        bcd_d   = '0;
                        cnt_d   = 4'd14;
                        state_d = StConverte;
                    end
                end
            end
            StConverte: begin
                {bcd_d, bin_d} = {bcd_adj[14:0], bin_q, 1'b0};
                cnt_d          = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = StAtualiza;
                end
            end
            StAtualiza: begin
                if (erro_q) begin
                    hex3_d  = SegBlank;
                    hex2_d  = SegE;
                    hex1_d  = SegR;
                    hex0_d  = SegR;
                    sinal_d = SegBlank;
                end else begin
                    hex3_d  = (d3 == 4'd0) ? SegBlank : seg_digito(d3);
                    hex2_d  = (d3 == 4'd0 && d2 == 4'd0) ? SegBlank : seg_digito(d2);
                    hex1_d  = (d3 == 4'd0 && d2 == 4'd0 && d1 == 4'd0) ? SegBlank
                                                                      : seg_digito(d1);
                    hex0_d  = seg_digito(d0);
                    sinal_d = neg_q ? SegMenos : SegBlank;
                end
                state_d = StOcioso;
            end
            default: state_d = StOcioso;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= StOcioso;
            neg_q   <= 1'b0;
            erro_q  <= 1'b0;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            hex0_q  <= 7'b1000000;
            hex1_q  <= SegBlank;
            hex2_q  <= SegBlank;
            hex3_q  <= SegBlank;
            sinal_q <= SegBlank;
        end else begin
            state_q <= state_d;
            neg_q   <= neg_d;
            erro_q  <= erro_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            hex0_q  <= hex0_d;
            hex1_q  <= hex1_d;
            hex2_q  <= hex2_d;
            hex3_q  <= hex3_d;
            sinal_q <= sinal_d;
        end
    end

    assign ocupado = (state_q != StOcioso);
    assign hex0    = ATIVO_BAIXO ? hex0_q : ~hex0_q;
    assign hex1    = ATIVO_BAIXO ? hex1_q : ~hex1_q;
    assign hex2    = ATIVO_BAIXO ? hex2_q : ~hex2_q;
    assign hex3    = ATIVO_BAIXO ? hex3_q : ~hex3_q;
    assign sinal   = ATIVO_BAIXO ? sinal_q : ~sinal_q;

endmodule

// File: doc/saida_de_dados_7seg.md
# saida_de_dados_7seg

Output peripheral for the processor's OUT instruction: the datapath write path that mirrors the switch-input block. It captures a 32-bit two's-complement word, converts its magnitude to four BCD digits with a sequential double-dabble engine, and drives four digit displays plus one sign display. It sits between the register-file read port and the board's 7-segment pins, and uses a busy flag to pace the control unit.

## Interface
- `ATIVO_BAIXO`, default 1: segment polarity. When 1, a segment is lit by driving 0; when 0, every segment pattern below is bitwise inverted.
- `clock` input 1: system clock; every register updates on the rising edge.
- `reset` input 1: synchronous, active-low reset, sampled on the rising edge of `clock`.
- `escrita` input 1: write strobe, one cycle wide, asserted by the control unit on OUT.
- `dado` input 32: value to display, interpreted as two's complement.
- `ocupado` output 1: high while a conversion is in progress; decoded combinationally from state.
- `hex0`..`hex3` output 7 each: digit displays, units through thousands; bit order {g,f,e,d,c,b,a}.
- `sinal` output 7: sign display, same bit order.

## Operation
- State machine with states OCIOSO, CONVERTE and ATUALIZA. `ocupado` is high in every state except OCIOSO.
- **OCIOSO, `escrita`=1:**
  - Latch the sign bit `neg` = `dado`[31].
  - Compute `mag` = `neg` ? (~`dado`+1) : `dado`, 32-bit.
  - If `mag` > 9999, set the error flag and go to ATUALIZA.
  - Otherwise load the shift register with `mag`[13:0], clear the 16-bit BCD accumulator, set the counter to 14, and go to CONVERTE.
  - 0x80000000 negates to itself, so it takes the error path.
- **CONVERTE, one step per cycle:** each BCD nibble that is ≥5 gets +3, then {bcd, bin} shifts left by one bit. After the 14th step, go to ATUALIZA.
- **ATUALIZA:** register all five display outputs from the BCD result, or from the error pattern, then go to OCIOSO.
- **Segment patterns (active-low):**
  - digits 0-9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000
  - blank: 1111111; minus: 0111111; E: 0000110; r: 0101111
- **Leading-zero blanking:**
  - `hex3` is blank when d3=0.
  - `hex2` is blank when d3=d2=0.
  - `hex1` is blank when d3=d2=d1=0.
  - `hex0` is always shown.
- **Sign display:** `sinal` shows minus when `neg`=1 and blank otherwise. The value −0 cannot occur.
- **Error pattern:** `hex3` blank, `hex2`=E, `hex1`=r, `hex0`=r, `sinal` blank.
- **Write while busy:** `escrita` while `ocupado`=1 is ignored and dropped, with no queueing. The displays keep the previous value until ATUALIZA.
- **Reset:** resets the state to OCIOSO and the counter to 0. It sets `hex3`..`hex1` blank, `hex0` to digit 0, and `sinal` blank. A reset mid-conversion aborts the conversion; no partial result ever reaches the outputs.

## Timing
- Edge E0 samples `escrita`=1 while in OCIOSO; `ocupado` goes high after E0.
- **Normal path:** edges E1..E14 perform the 14 shift steps. At E15 the outputs update and the state returns to OCIOSO, so `ocupado` falls after E15. Latency from the strobe to visible outputs is 15 cycles.
- **Error path:** E1 updates the outputs and returns to OCIOSO. Latency is 1 cycle; `ocupado` is high for exactly 1 cycle.
- **Back-to-back writes:** a new `escrita` is accepted on the first edge with the state in OCIOSO, i.e. the cycle after E15.
- `reset`=0 takes priority over `escrita` on the same edge.
- The outputs are registered and change only at the ATUALIZA edge or on reset.

## Test plan
- **Reset:** hold `reset`=0 for 2 cycles. Then `hex0`=1000000, `hex1`..`hex3`=1111111, `sinal`=1111111, `ocupado`=0.
- **Positive value:** write `dado`=1234. Then `ocupado` is high for exactly 15 cycles, and after that `hex3`=1111001, `hex2`=0100100, `hex1`=0110000, `hex0`=0011001, `sinal` blank.
- **Negative with blanking:** write 0xFFFFFFF9 (−7). Then `sinal`=0111111, `hex0`=1111000, `hex1`..`hex3` blank. Also write 0xFFFFD8F1 (−9999): `sinal`=minus and all four digits=0010000.
- **Overflow:** write 10000, then 0x80000000. In both cases `ocupado` is high for 1 cycle and the outputs show blank, E, r, r with `sinal` blank.
- **Write while busy:** write 42, then pulse `escrita` with 999 at E5. The 999 is ignored: the result shows `hex1`=0011001, `hex0`=0100100, and `ocupado` stays at 15 cycles.
- **Reset mid-conversion:** write 5678, then assert `reset`=0 at E7. The outputs return to reset values, `ocupado`=0, and they never show 5678. A following write of 0 yields `hex0`=1000000 with the rest blank.
